// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-step multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH working register.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_is_div;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic                 r_div_zero;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  // op[1] selects divide, op[0] selects signed.
  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;

  assign w_is_div = op[1];
  assign w_signed = op[0];
  assign w_b_zero = (B == '0);
  assign w_a_abs  = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_abs  = (w_signed && B[WIDTH-1]) ? -B : B;

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_mul_step;

  assign w_add      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_add, r_prod[WIDTH-1:1]};

  // Divide step: {remainder, dividend} shifts left, quotient bit enters at LSB.
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_sub;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_next;
  logic [2*WIDTH-1:0]   w_div_step;

  assign w_shift    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opnd});
  assign w_sub      = w_shift - {1'b0, r_opnd};
  assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_step = {w_rem_next, r_prod[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_prod_fix = r_neg_lo ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_lo ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = (w_is_div && w_b_zero) ? S_FINISH : S_RUN;
      S_RUN:    if (r_count == CW'(ITER - 1)) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the working register is small enough to reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_prod     <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_count    <= '0;
            r_is_div   <= w_is_div;
            r_neg_lo   <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_hi   <= w_signed & w_is_div & A[WIDTH-1];
            r_div_zero <= w_is_div & w_b_zero;
            r_prod     <= w_is_div ? {{WIDTH{1'b0}}, w_a_abs} : {{WIDTH{1'b0}}, w_b_abs};
            r_opnd     <= w_is_div ? w_b_abs : w_a_abs;
          end
        end
        S_RUN: begin
          r_prod  <= r_is_div ? w_div_step : w_mul_step;
          r_count <= r_count + 1'b1;
        end
        S_FINISH: begin
          r_done <= 1'b1;
          if (!r_div_zero) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle iterative multiply/divide unit that owns the architectural HI/LO registers for the datapath.
- The combinational ALU issues MULT/MULTU/DIV/DIVU operations; this block executes them over 32 iterations and holds the results until MFHI/MFLO read them.
- Also accepts MTHI/MTLO writes.
- Gives the pipeline a start/busy/done handshake so it can stall on HI/LO hazards.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- ITER, 32, iterations per mul/div; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request new operation; sampled only when busy=0
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  input  WIDTH  multiplicand / dividend (rs)
- B  input  WIDTH  multiplier / divisor (rt)
- mthi  input  1  write wdata into HI
- mtlo  input  1  write wdata into LO
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO hold new result
- div_zero  output  1  last DIV/DIVU had B=0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous, any state, including mid-operation):
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - FSM goes to IDLE; iteration counter and operand registers clear.
  - The in-flight operation is discarded.
- FSM states IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge T: latch |A|, |B| for signed ops (raw values for unsigned) and latch result signs. For MULT the sign is A[31]^B[31]. For DIV the quotient sign is A[31]^B[31] and the remainder sign is A[31].
  - Clear div_zero, count=0, go to RUN.
  - Exception: DIV/DIVU with B=0 goes straight to FINISH and sets div_zero=1.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; count increments.
  - After ITER steps, go to FINISH.
- FINISH:
  - Apply two's-complement sign correction, write HI/LO, go to IDLE.
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
  - Div-by-zero: HI/LO are not written.
- Timing for start sampled at edge T:
  - busy=1 from cycle T+1 through T+33.
  - done=1 for exactly cycle T+34, with new hi/lo visible in that cycle; busy=0 in the done cycle.
  - Div-by-zero: busy=1 for cycle T+1 only; done=1 in cycle T+2.
- A start asserted in the done cycle is accepted; back-to-back throughput is one operation per 34 cycles.
- start while busy=1 is ignored (not queued).
- mthi/mtlo:
  - Honoured only when busy=0; the write takes effect at that edge.
  - Ignored while busy=1.
  - A same-edge start+mthi writes HI now; the operation result later overwrites it.
  - mthi and mtlo may both be asserted; both registers are written.
- Signed corner cases (32-bit wrap, no trap):
  - MULT 0x80000000*0x80000000 gives HI=0x40000000, LO=0.
  - DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- Unsigned ops treat all 32 bits as magnitude.
- hi/lo are stable outside writes.

Test Plan:
- Reset mid-RUN (assert rst_n=0 at cycle T+10 of a MULTU) -> hi=lo=0, busy=0 immediately; no done pulse afterwards.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at T+34, HI=0xFFFFFFFE, LO=0x00000001; busy high T+1..T+33.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV A=-7 (0xFFFFFFF9) B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100 B=7 -> LO=14, HI=2.
- DIVU A=5 B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> done at T+2, div_zero=1, HI/LO unchanged; next start clears div_zero.
- During busy: start pulse and MTLO wdata=0xAB -> both ignored; the first result is returned and LO is not 0xAB. In the done cycle, a new start is accepted.
